file_load_ctrl: RTL
===================

// Module: file_load_ctrl
// PURPOSE
//  Sequences a block load of captured words into RAM for the DCNN IO path.
//  Accepts a start command (base address, word count), streams words in via a
//  valid/ready handshake, and issues one RAM write per word at consecutive addresses.
//  Sits between the capture front-end and the RAM write port; replaces a fixed-address load.
// PARAMETERS
//  DATA_W  16  width of captured word / RAM data
//  ADDR_W  16  RAM address width
//  CNT_W   16  width of word-count field
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  RST            in   1       asynchronous reset, active-high
//  start          in   1       1-cycle command strobe, sampled only in IDLE
//  ramBase        in   ADDR_W  first RAM address, sampled with start
//  wordCount      in   CNT_W   number of words to load, sampled with start
//  abort          in   1       cancel an in-progress load
//  capture_valid  in   1       captured_data holds a word
//  captured_data  in   DATA_W  word from capture front-end
//  capture_ready  out  1       controller accepts a word this cycle
//  write          out  1       RAM write strobe, registered
//  ramAddress     out  ADDR_W  RAM write address, registered
//  ramData        out  DATA_W  RAM write data, registered
//  busy           out  1       high in LOAD
//  done           out  1       1-cycle pulse: load completed
//  err            out  1       1-cycle pulse: command rejected or aborted
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE; write, ramAddress, ramData, busy, done, err all 0;
//   address/remaining counters 0. Reset mid-load discards the load; no further writes.
//  States: IDLE -> LOAD -> DONE -> IDLE (2-bit encoding).
//  IDLE: capture_ready=0. On start:
//   - wordCount==0: done=1 next cycle, stay IDLE, no write.
//   - ramBase+wordCount > 2**ADDR_W (compare at ADDR_W+1 bits): err=1 next cycle, stay IDLE.
//   - else latch addr=ramBase, remaining=wordCount, go LOAD.
//  LOAD: busy=1, capture_ready=1 (combinational from state, no dependency on valid).
//   - Handshake: transfer when capture_valid&&capture_ready. Next cycle write=1,
//     ramAddress=addr, ramData=captured_data; addr+=1, remaining-=1. Latency 1 clock.
//   - No transfer: write=0 next cycle; ramAddress/ramData hold last value.
//   - Transfer with remaining==1: go DONE.
//   - abort=1: abort wins over a simultaneous transfer (no write for that word);
//     go IDLE, err=1 next cycle.
//   - start ignored in LOAD and DONE.
//  DONE: done=1, write=1 for the final word in the same cycle, capture_ready=0,
//   busy=0; unconditionally return to IDLE. A start in DONE is ignored.
//  Address never wraps: the range check in IDLE guarantees it. The last legal
//   address is 2**ADDR_W-1.
//  done and err are mutually exclusive and never asserted for more than 1 cycle.
// STRUCTURE
//  Shared package dcnn_io_pkg: state localparams (IDLE=0, LOAD=1, DONE=2) and
//   default width constants (DATA_W, ADDR_W, CNT_W).
//  The FSM, output registers and range check live in this module.
//  Optional sub-module load_addr_counter: loadable address incrementer plus
//   down-counter with a last flag.
// TESTING
//  1. start, ramBase=0x0100, wordCount=4, valid held high, data A,B,C,D ->
//     writes at 0x0100..0x0103 on 4 consecutive cycles, done on the cycle of the 0x0103 write.
//  2. Same command, valid toggling 1,0,1,0 -> writes only the cycle after each
//     transfer, addresses contiguous, busy high until DONE.
//  3. start, ramBase=0xFFFE, wordCount=3 -> err pulse, no write, stays IDLE.
//     ramBase=0xFFFE, wordCount=2 -> accepted; writes at 0xFFFE and 0xFFFF.
//  4. start, wordCount=0 -> single done pulse, no write, capture_ready stays 0.
//  5. Load of 8 words, abort asserted together with the 3rd transfer ->
//     exactly 2 writes, err pulse, IDLE; a new start is then accepted normally.
//  6. RST pulsed after 2 of 5 words -> all outputs 0 immediately, no further
//     writes; start in LOAD/DONE ignored.

Source files
------------

// File: rtl/dcnn_io_pkg.sv
// Shared types and default widths for the DCNN IO path.
// Used by the RAM block-load controller.
package dcnn_io_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Loadable RAM address incrementer plus remaining-word down-counter.
// o_last flags the final word of the block.
module load_addr_counter #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_count;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_rem  <= r_rem - CNT_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/file_load_ctrl.sv
// Block-load sequencer: streams captured words into RAM at
// consecutive addresses starting at a commanded base.
module file_load_ctrl #(
  parameter int DATA_W = dcnn_io_pkg::DEF_DATA_W,
  parameter int ADDR_W = dcnn_io_pkg::DEF_ADDR_W,
  parameter int CNT_W  = dcnn_io_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] ramBase,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic              abort,
  input  logic              capture_valid,
  input  logic [DATA_W-1:0] captured_data,
  output logic              capture_ready,
  output logic              write,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramData,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import dcnn_io_pkg::*;

  localparam int SW = (ADDR_W > CNT_W ? ADDR_W : CNT_W) + 1;

  load_state_t       r_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [SW-1:0]     w_sum;
  logic              w_over;
  logic              w_zero;
  logic              w_accept;
  logic              w_xfer;
  logic              w_step;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  // Widened sum so a block ending exactly at the top address is legal.
  assign w_sum    = SW'(ramBase) + SW'(wordCount);
  assign w_over   = w_sum > (SW'(1) << ADDR_W);
  assign w_zero   = (wordCount == '0);
  assign w_accept = (r_state == IDLE) && start && !w_zero && !w_over;

  assign capture_ready = (r_state == LOAD);
  assign w_xfer = capture_valid && capture_ready;
  assign w_step = w_xfer && !abort;

  load_addr_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (RST),
    .i_load  (w_accept),
    .i_step  (w_step),
    .i_base  (ramBase),
    .i_count (wordCount),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              w_zero: r_done <= 1'b1;
              w_over: r_err  <= 1'b1;
              default: begin
                r_state <= LOAD;
                r_busy  <= 1'b1;
              end
            endcase
          end
        end
        LOAD: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_xfer) begin
            r_write <= 1'b1;
            r_addr  <= w_addr;
            r_data  <= captured_data;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign write      = r_write;
  assign ramAddress = r_addr;
  assign ramData    = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
